// File: rtl/operand_bypass.sv
// operand_bypass
//   Operand forwarding for the EXE stage.
//   Each ALU operand (rs -> opA, rt -> opB) comes from one of three places:
//   the result one instruction ahead (exeValue), the result two instructions
//   ahead (memLatch), or the register file. The Exe path wins when both
//   forward flags are set. If the instruction one ahead is a load whose data
//   has not arrived yet, and an operand wants it, the front of the pipe
//   stalls until loadValid rises.
//
// Ports
//   CLK, RESET                    clock, async active-low reset
//   forwardFromExe2rs/rt          take rs/rt from the result one ahead
//   forwardFromMem2rs/rt          take rs/rt from the result two ahead
//   rsData, rtData                register-file operands for the EXE instruction
//   aluOut, exeIsLoad             result / load flag of the EXE instruction
//   loadData, loadValid           memory read data for the load in MEM
//   opA, opB                      selected operands to the ALU
//   stall                         freeze IF/ID/EXE this cycle
//   stallCycles                   saturating count of stalled cycles

// One operand selector. Exe beats Mem beats the register file.
module bypass_lane #(
    parameter int DATA_W = 32
) (
    input  logic              fwdExe,
    input  logic              fwdMem,
    input  logic [DATA_W-1:0] exeValue,
    input  logic [DATA_W-1:0] memValue,
    input  logic [DATA_W-1:0] regValue,
    output logic [DATA_W-1:0] opValue
);
    always_comb begin
        opValue = regValue;
        if (fwdExe)      opValue = exeValue;
        else if (fwdMem) opValue = memValue;
    end
endmodule

module operand_bypass #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              forwardFromExe2rs,
    input  logic              forwardFromExe2rt,
    input  logic              forwardFromMem2rs,
    input  logic              forwardFromMem2rt,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic [DATA_W-1:0] aluOut,
    input  logic              exeIsLoad,
    input  logic [DATA_W-1:0] loadData,
    input  logic              loadValid,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic              stall,
    output logic [15:0]       stallCycles
);
    localparam int NUM_OPS = 2;  // lane 0 = rs/opA, lane 1 = rt/opB

    typedef enum logic {RUN, LOAD_WAIT} state_t;

    // Forwarding request for one operand.
    typedef struct packed {
        logic fwdExe;
        logic fwdMem;
    } fwdReq_t;

    state_t            state;
    logic [DATA_W-1:0] exeLatch;
    logic              exeLatchIsLoad;
    logic [DATA_W-1:0] memLatch;
    logic [DATA_W-1:0] exeValue;
    logic              hazard;

    fwdReq_t [NUM_OPS-1:0]             req;
    logic    [NUM_OPS-1:0][DATA_W-1:0] regVal;
    logic    [NUM_OPS-1:0][DATA_W-1:0] opVal;

    // A load one ahead has no result of its own; its value is whatever memory
    // returns this cycle.
    assign exeValue = exeLatchIsLoad ? loadData : exeLatch;

    assign req[0]    = '{fwdExe: forwardFromExe2rs, fwdMem: forwardFromMem2rs};
    assign req[1]    = '{fwdExe: forwardFromExe2rt, fwdMem: forwardFromMem2rt};
    assign regVal[0] = rsData;
    assign regVal[1] = rtData;

    for (genvar i = 0; i < NUM_OPS; i++) begin : gLane
        bypass_lane #(.DATA_W(DATA_W)) uLane (
            .fwdExe   (req[i].fwdExe),
            .fwdMem   (req[i].fwdMem),
            .exeValue (exeValue),
            .memValue (memLatch),
            .regValue (regVal[i]),
            .opValue  (opVal[i])
        );
    end

    assign opA = opVal[0];
    assign opB = opVal[1];

    // Only an Exe-forward from an outstanding load can stall; memLatch always
    // holds final data. Release is combinational the cycle loadValid rises.
    assign hazard = (forwardFromExe2rs | forwardFromExe2rt) & exeLatchIsLoad & ~loadValid;
    assign stall  = hazard;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= RUN;
            exeLatch       <= '0;
            exeLatchIsLoad <= 1'b0;
            memLatch       <= '0;
            stallCycles    <= '0;
        end else begin
            case (state)
                RUN:       state <= hazard ? LOAD_WAIT : RUN;
                LOAD_WAIT: state <= hazard ? LOAD_WAIT : RUN;
                default:   state <= RUN;
            endcase

            if (!stall) begin
                exeLatch       <= aluOut;
                exeLatchIsLoad <= exeIsLoad;
                memLatch       <= exeValue;
            end else if (stallCycles != 16'hFFFF) begin
                stallCycles <= stallCycles + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_operand_bypass.sv
module tb_operand_bypass;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        forwardFromExe2rs, forwardFromExe2rt;
    logic        forwardFromMem2rs, forwardFromMem2rt;
    logic [31:0] rsData, rtData, aluOut, loadData;
    logic        exeIsLoad, loadValid;
    logic [31:0] opA, opB;
    logic        stall;
    logic [15:0] stallCycles;

    int checks = 0;
    int errors = 0;

    operand_bypass dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .forwardFromExe2rs (forwardFromExe2rs),
        .forwardFromExe2rt (forwardFromExe2rt),
        .forwardFromMem2rs (forwardFromMem2rs),
        .forwardFromMem2rt (forwardFromMem2rt),
        .rsData            (rsData),
        .rtData            (rtData),
        .aluOut            (aluOut),
        .exeIsLoad         (exeIsLoad),
        .loadData          (loadData),
        .loadValid         (loadValid),
        .opA               (opA),
        .opB               (opB),
        .stall             (stall),
        .stallCycles       (stallCycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are changed 1ns later, checks 1ns after that.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setFwd(input logic eRs, input logic eRt, input logic mRs, input logic mRt);
        forwardFromExe2rs = eRs;
        forwardFromExe2rt = eRt;
        forwardFromMem2rs = mRs;
        forwardFromMem2rt = mRt;
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        setFwd(0, 0, 0, 0);
        rsData = 32'h1234; rtData = 32'h5678;
        aluOut = 32'h0; exeIsLoad = 1'b0; loadData = 32'h0; loadValid = 1'b0;
        #1;
        // Reset state
        check("rst_opA", opA, 32'h1234);
        check("rst_opB", opB, 32'h5678);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_cnt", {16'd0, stallCycles}, 32'd0);
        tick();
        RESET = 1'b1;

        // Exe forward: 0x11 latched on edge N, used at N+1
        aluOut = 32'h11;
        tick();
        setFwd(1, 0, 0, 0);
        check("exe_opA", opA, 32'h11);
        check("exe_stall", {31'd0, stall}, 32'd0);
        check("exe_opB_reg", opB, 32'h5678);

        // Mem forward: 0x22 then 0x33
        setFwd(0, 0, 0, 0);
        aluOut = 32'h22; tick();
        aluOut = 32'h33; tick();
        setFwd(1, 0, 0, 1);
        check("mem_opB", opB, 32'h22);
        check("mem_exe_opA", opA, 32'h33);

        // Priority: exeValue=0xA, memLatch=0xB, both rs flags set
        setFwd(0, 0, 0, 0);
        aluOut = 32'hB; tick();
        aluOut = 32'hA; tick();
        setFwd(1, 0, 1, 1);
        check("prio_opA", opA, 32'hA);
        check("prio_opB_mem", opB, 32'hB);

        // Load-use: load latched, rt wants it, data late by 3 cycles
        setFwd(0, 0, 0, 0);
        aluOut = 32'hDEAD; exeIsLoad = 1'b1; tick();
        exeIsLoad = 1'b0; aluOut = 32'h77; loadValid = 1'b0; loadData = 32'h0;
        setFwd(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lu_stall%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        check("lu_cnt3", {16'd0, stallCycles}, 32'd3);
        loadData = 32'hCAFE; loadValid = 1'b1; #1;
        check("lu_release", {31'd0, stall}, 32'd0);
        check("lu_opB", opB, 32'hCAFE);
        tick();
        loadValid = 1'b0; loadData = 32'h0;
        setFwd(1, 0, 0, 1);
        check("lu_memLatch", opB, 32'hCAFE);
        check("lu_exeLatch", opA, 32'h77);
        check("lu_cnt_hold", {16'd0, stallCycles}, 32'd3);
        // loadValid ignored for a non-load; mem flags never stall
        setFwd(0, 1, 1, 0);
        check("nl_stall", {31'd0, stall}, 32'd0);
        check("nl_opB", opB, 32'h77);
        check("nl_opA", opA, 32'hCAFE);

        // Reset in the middle of LOAD_WAIT
        setFwd(0, 0, 0, 0);
        aluOut = 32'h99; exeIsLoad = 1'b1; tick();
        exeIsLoad = 1'b0;
        setFwd(1, 0, 0, 0);
        check("rw_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rw_cnt", {16'd0, stallCycles}, 32'd4);
        loadData = 32'h5555;
        RESET = 1'b0; #1;
        check("rw_async_stall", {31'd0, stall}, 32'd0);
        check("rw_async_cnt", {16'd0, stallCycles}, 32'd0);
        check("rw_exeLatch", opA, 32'h0);
        setFwd(0, 0, 1, 0);
        check("rw_memLatch", opA, 32'h0);
        tick();
        RESET = 1'b1;
        setFwd(1, 0, 0, 0);
        check("rw_after_stall", {31'd0, stall}, 32'd0);
        check("rw_after_opA", opA, 32'h0);
        setFwd(0, 0, 0, 0);
        check("rw_after_reg", opA, 32'h1234);

        // Saturation: 65540 stalled edges
        aluOut = 32'h1; exeIsLoad = 1'b1; loadValid = 1'b0; tick();
        exeIsLoad = 1'b0;
        setFwd(1, 0, 0, 0);
        check("sat_stall", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 65535; i++) tick();
        check("sat_max", {16'd0, stallCycles}, 32'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", {16'd0, stallCycles}, 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_bypass.md
OPERAND_BYPASS -- requirements
Module: operand_bypass

Interface
REQ-001 SHALL have port CLK  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port forwardFromExe2rs  input  1  take rs operand from the result one instruction ahead.
REQ-004 SHALL have port forwardFromExe2rt  input  1  take rt operand from the result one instruction ahead.
REQ-005 SHALL have port forwardFromMem2rs  input  1  take rs operand from the result two instructions ahead.
REQ-006 SHALL have port forwardFromMem2rt  input  1  take rt operand from the result two instructions ahead.
REQ-007 SHALL have port rsData  input  32  register-file rs value for the instruction in EXE.
REQ-008 SHALL have port rtData  input  32  register-file rt value for the instruction in EXE.
REQ-009 SHALL have port aluOut  input  32  ALU result of the instruction in EXE.
REQ-010 SHALL have port exeIsLoad  input  1  instruction in EXE is a load.
REQ-011 SHALL have port loadData  input  32  memory read data for the load in MEM.
REQ-012 SHALL have port loadValid  input  1  loadData valid this cycle.
REQ-013 SHALL have port opA  output  32  selected rs operand to ALU.
REQ-014 SHALL have port opB  output  32  selected rt operand to ALU.
REQ-015 SHALL have port stall  output  1  freeze IF/ID/EXE this cycle.
REQ-016 SHALL have port stallCycles  output  16  saturating count of stalled cycles.

Function
REQ-017 SHALL hold internal registers exeLatch[31:0], exeLatchIsLoad, memLatch[31:0], state in {RUN, LOAD_WAIT}.
REQ-018 SHALL define exeValue = exeLatchIsLoad ? loadData : exeLatch (combinational).
REQ-019 SHALL drive opA = forwardFromExe2rs ? exeValue : forwardFromMem2rs ? memLatch : rsData; Exe wins when both set.
REQ-020 SHALL drive opB by the same rule using rt flags and rtData.
REQ-021 SHALL define hazard = (forwardFromExe2rs | forwardFromExe2rt) & exeLatchIsLoad & !loadValid.
REQ-022 SHALL drive stall = hazard combinationally, in both states; zero-latency release the cycle loadValid rises.
REQ-023 SHALL, in RUN, move to LOAD_WAIT on a clock edge where hazard=1, else stay in RUN.
REQ-024 SHALL, in LOAD_WAIT, stay while hazard=1 and return to RUN on the edge where hazard=0.
REQ-025 SHALL, on each edge with stall=0: exeLatch<=aluOut, exeLatchIsLoad<=exeIsLoad, memLatch<=exeValue.
REQ-026 SHALL hold exeLatch, exeLatchIsLoad, memLatch unchanged on each edge with stall=1.
REQ-027 SHALL increment stallCycles by 1 on each edge with stall=1, saturating at 16'hFFFF (no wrap).
REQ-028 SHALL ignore loadValid when exeLatchIsLoad=0; memLatch then receives exeLatch.
REQ-029 SHALL not stall on Mem-forward flags; memLatch is always final data.

Reset
REQ-030 SHALL, while RESET=0, clear exeLatch, memLatch, exeLatchIsLoad, stallCycles to 0 and set state RUN, independent of CLK.
REQ-031 SHALL, after reset with all forward flags 0, output opA=rsData, opB=rtData, stall=0.
REQ-032 SHALL, when RESET asserts in LOAD_WAIT, abandon the wait; stall=0 in the first cycle after release unless hazard recurs.

Verification
REQ-033 SHALL cover Exe forward: aluOut=0x11 on edge N (exeIsLoad=0), forwardFromExe2rs=1 at N+1 -> opA=0x11, stall=0.
REQ-034 SHALL cover Mem forward: aluOut=0x22 then 0x33 on consecutive edges, forwardFromMem2rt=1 -> opB=0x22.
REQ-035 SHALL cover priority: both rs flags set, exeValue=0xA, memLatch=0xB -> opA=0xA.
REQ-036 SHALL cover load-use: exeIsLoad=1 latched, forwardFromExe2rt=1, loadValid low 3 cycles then loadData=0xCAFE valid -> stall=1 for 3 cycles, opB=0xCAFE on release, stallCycles=3, then memLatch=0xCAFE.
REQ-037 SHALL cover saturation: force 65540 stall cycles -> stallCycles=0xFFFF.
REQ-038 SHALL cover reset mid-LOAD_WAIT: RESET low 1 cycle during stall -> stall=0, latches 0, stallCycles=0.
